// File: rtl/dpram_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dpram_port_arbiter_if
// Bundles the requester-side command/response signals and the RAM-side port
// signals of dpram_port_arbiter.
//   req/lock/we/addr/wdata : per-requester command, packed [i*W +: W]
//   ack/rvalid/rdata       : per-requester grant, read-valid strobe, shared data
//   ram_wren/ram_address/ram_data/ram_q : one port of the dual-port RAM
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus the RAM returning ram_q)
// -----------------------------------------------------------------------------
interface dpram_port_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ADRW = 8,
    parameter int unsigned DATW = 8
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      lock;
    logic [NREQ-1:0]      we;
    logic [NREQ*ADRW-1:0] addr;
    logic [NREQ*DATW-1:0] wdata;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      rvalid;
    logic [DATW-1:0]      rdata;
    logic                 ram_wren;
    logic [ADRW-1:0]      ram_address;
    logic [DATW-1:0]      ram_data;
    logic [DATW-1:0]      ram_q;

    modport slave (
        input  req, lock, we, addr, wdata, ram_q,
        output ack, rvalid, rdata, ram_wren, ram_address, ram_data
    );

    modport master (
        output req, lock, we, addr, wdata, ram_q,
        input  ack, rvalid, rdata, ram_wren, ram_address, ram_data
    );
endinterface

// File: rtl/dpram_port_arbiter.sv
// -----------------------------------------------------------------------------
// dpram_port_arbiter
// Shares one port of a dual-port RAM between NREQ requesters. Round-robin
// arbitration with optional locked bursts (at most MAXBURST consecutive grants
// while others wait). The winning command is registered onto ram_*; read data
// comes back two cycles after acceptance with a per-requester rvalid strobe.
//
// Ports:
//   clock : single clock for arbiter and RAM
//   reset : asynchronous, active-high reset
//   bus   : dpram_port_arbiter_if.slave (requester commands, ack/rvalid/rdata,
//           RAM port ram_wren/ram_address/ram_data/ram_q)
//
// Optional feature macro: DPRAM_ARB_FIXED_PRIO_EN
//   defined   : requester 0 wins whenever it requests, preempting bursts; it does
//               not move the round-robin pointer, and 1..NREQ-1 rotate among
//               themselves.
//   undefined : requester 0 is an ordinary round-robin member.
// -----------------------------------------------------------------------------
module dpram_port_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned ADRW     = 8,
    parameter int unsigned DATW     = 8,
    parameter int unsigned MAXBURST = 4
) (
    input logic                 clock,
    input logic                 reset,
    dpram_port_arbiter_if.slave bus
);
    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CntW = 4;
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAXBURST);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NREQ - 1);

    // rr_ptr_q is the first index examined by the next round-robin search
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic            owner_vld_q, owner_vld_d;
    logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
    logic            ram_wren_q, ram_wren_d;
    logic [ADRW-1:0] ram_address_q, ram_address_d;
    logic [DATW-1:0] ram_data_q, ram_data_d;
    logic            rd_vld1_q, rd_vld1_d;
    logic [IdxW-1:0] rd_id1_q, rd_id1_d;
    logic            rd_vld2_q, rd_vld2_d;
    logic [IdxW-1:0] rd_id2_q, rd_id2_d;

    logic            gnt_vld;
    logic [IdxW-1:0] gnt_idx;
    logic            hold_win;
    logic            burst_hold;
    logic            burst_expired;
    logic [NREQ-1:0] owner_onehot;
    logic [NREQ-1:0] rr_mask;
    logic [IdxW-1:0] cand;

    // Arbitration
    always_comb begin
        gnt_vld       = 1'b0;
        gnt_idx       = '0;
        hold_win      = 1'b0;
        cand          = '0;
        owner_onehot  = NREQ'(1) << owner_q;
        burst_hold    = owner_vld_q && bus.req[owner_q] && bus.lock[owner_q];
        burst_expired = (burst_cnt_q >= MaxCnt) && (|(bus.req & ~owner_onehot));
        rr_mask       = bus.req;
        // An expired burst owner sits out exactly one round
        if (burst_hold && burst_expired) begin
            rr_mask = rr_mask & ~owner_onehot;
        end
`ifdef DPRAM_ARB_FIXED_PRIO_EN
        rr_mask[0] = 1'b0;
`endif
        if (burst_hold && !burst_expired) begin
            gnt_vld  = 1'b1;
            gnt_idx  = owner_q;
            hold_win = 1'b1;
        end else begin
            for (int k = 0; k < int'(NREQ); k++) begin
                cand = IdxW'((int'(rr_ptr_q) + k) % int'(NREQ));
                if (!gnt_vld && rr_mask[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
`ifdef DPRAM_ARB_FIXED_PRIO_EN
        if (bus.req[0]) begin
            gnt_vld  = 1'b1;
            gnt_idx  = '0;
            hold_win = owner_vld_q && (owner_q == '0) && bus.lock[0];
        end
`endif
    end

    // Next state
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        owner_vld_d   = 1'b0;
        burst_cnt_d   = '0;
        ram_wren_d    = 1'b0;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        rd_vld1_d     = 1'b0;
        rd_id1_d      = rd_id1_q;
        rd_vld2_d     = rd_vld1_q;
        rd_id2_d      = rd_id1_q;
        if (gnt_vld) begin
            owner_vld_d = 1'b1;
            owner_d     = gnt_idx;
            if (hold_win) begin
                burst_cnt_d = (burst_cnt_q >= MaxCnt) ? MaxCnt : burst_cnt_q + 1'b1;
            end else begin
                burst_cnt_d = CntW'(1);
            end
`ifdef DPRAM_ARB_FIXED_PRIO_EN
            if (gnt_idx != '0) begin
                rr_ptr_d = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
            end
`else
            rr_ptr_d = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
`endif
            ram_wren_d    = bus.we[gnt_idx];
            ram_address_d = bus.addr[int'(gnt_idx)*ADRW +: ADRW];
            ram_data_d    = bus.wdata[int'(gnt_idx)*DATW +: DATW];
            rd_vld1_d     = !bus.we[gnt_idx];
            rd_id1_d      = gnt_idx;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            owner_vld_q   <= 1'b0;
            burst_cnt_q   <= '0;
            ram_wren_q    <= 1'b0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            rd_vld1_q     <= 1'b0;
            rd_id1_q      <= '0;
            rd_vld2_q     <= 1'b0;
            rd_id2_q      <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            owner_vld_q   <= owner_vld_d;
            burst_cnt_q   <= burst_cnt_d;
            ram_wren_q    <= ram_wren_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            rd_vld1_q     <= rd_vld1_d;
            rd_id1_q      <= rd_id1_d;
            rd_vld2_q     <= rd_vld2_d;
            rd_id2_q      <= rd_id2_d;
        end
    end

    // ack is masked during reset so nothing appears accepted while flops are held
    assign bus.ack         = (gnt_vld && !reset) ? (NREQ'(1) << gnt_idx) : '0;
    assign bus.rvalid      = rd_vld2_q ? (NREQ'(1) << rd_id2_q) : '0;
    assign bus.rdata       = bus.ram_q;
    assign bus.ram_wren    = ram_wren_q;
    assign bus.ram_address = ram_address_q;
    assign bus.ram_data    = ram_data_q;
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dpram_port_arbiter
// Directed self-checking bench for dpram_port_arbiter with a registered-read
// RAM model on the arbitrated port.
// -----------------------------------------------------------------------------
module tb_dpram_port_arbiter;
    localparam int unsigned NREQ     = 4;
    localparam int unsigned ADRW     = 8;
    localparam int unsigned DATW     = 8;
    localparam int unsigned MAXBURST = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    dpram_port_arbiter_if #(.NREQ(NREQ), .ADRW(ADRW), .DATW(DATW)) bus ();

    dpram_port_arbiter #(
        .NREQ(NREQ), .ADRW(ADRW), .DATW(DATW), .MAXBURST(MAXBURST)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // RAM port model: registered read, 1-cycle latency
    logic [DATW-1:0] mem [256];
    always @(posedge clock) begin
        if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
        bus.ram_q <= mem[bus.ram_address];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req   = '0;
        bus.lock  = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
    endtask

    task automatic drive(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
        bus.req[i]                = 1'b1;
        bus.we[i]                 = w;
        bus.addr[i*ADRW +: ADRW]  = a;
        bus.wdata[i*DATW +: DATW] = d;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        bus.req = 4'b1111;
        #1;
        checks++;
        if (bus.ack !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ack got=%b exp=0000", bus.ack);
        end
        checks++;
        if (bus.rvalid !== 4'b0000) begin
            failures++;
            $display("FAIL reset_rvalid got=%b exp=0000", bus.rvalid);
        end
        checks++;
        if (bus.ram_wren !== 1'b0) begin
            failures++;
            $display("FAIL reset_wren got=%b exp=0", bus.ram_wren);
        end
        checks++;
        if (bus.ram_address !== 8'h00 || bus.ram_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_ram got=%h/%h exp=00/00", bus.ram_address, bus.ram_data);
        end
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        drive(3, 1'b1, 8'h10, 8'hA5);
        #1;
        checks++;
        if (bus.ack !== 4'b1000) begin
            failures++;
            $display("FAIL preload_ack got=%b exp=1000", bus.ack);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (bus.ram_wren !== 1'b1 || bus.ram_address !== 8'h10 || bus.ram_data !== 8'hA5) begin
            failures++;
            $display("FAIL preload_ram got=%b/%h/%h exp=1/10/a5",
                     bus.ram_wren, bus.ram_address, bus.ram_data);
        end
        tick();
        drive(2, 1'b0, 8'h10, 8'h00);
        #1;
        checks++;
        if (bus.ack !== 4'b0100) begin
            failures++;
            $display("FAIL read_ack got=%b exp=0100", bus.ack);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (bus.ram_address !== 8'h10 || bus.ram_wren !== 1'b0 || bus.rvalid !== 4'b0000) begin
            failures++;
            $display("FAIL read_c1 got=%h/%b/%b exp=10/0/0000",
                     bus.ram_address, bus.ram_wren, bus.rvalid);
        end
        tick();
        checks++;
        if (bus.rvalid !== 4'b0100 || bus.rdata !== 8'hA5) begin
            failures++;
            $display("FAIL read_c2 got=%b/%h exp=0100/a5", bus.rvalid, bus.rdata);
        end
        checks++;
        if (bus.ram_wren !== 1'b0 || bus.ram_address !== 8'h10) begin
            failures++;
            $display("FAIL idle_hold got=%b/%h exp=0/10", bus.ram_wren, bus.ram_address);
        end
        tick();
        checks++;
        if (bus.rvalid !== 4'b0000) begin
            failures++;
            $display("FAIL read_c3 got=%b exp=0000", bus.rvalid);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_ack [6];
`ifdef DPRAM_ARB_FIXED_PRIO_EN
        exp_ack = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
`endif
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (bus.ack !== exp_ack[i]) begin
                failures++;
                $display("FAIL rr_cycle%0d got=%b exp=%b", i, bus.ack, exp_ack[i]);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        do_reset();
        drive(1, 1'b1, 8'h20, 8'h3C);
        #1;
        checks++;
        if (bus.ack !== 4'b0010) begin
            failures++;
            $display("FAIL wr_ack got=%b exp=0010", bus.ack);
        end
        tick();
        drive(1, 1'b0, 8'h20, 8'h00);
        #1;
        checks++;
        if (bus.ack !== 4'b0010 || bus.ram_wren !== 1'b1 || bus.ram_data !== 8'h3C) begin
            failures++;
            $display("FAIL wr_rd_c1 got=%b/%b/%h exp=0010/1/3c",
                     bus.ack, bus.ram_wren, bus.ram_data);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (bus.rvalid !== 4'b0000 || bus.ram_wren !== 1'b0 || bus.ram_address !== 8'h20) begin
            failures++;
            $display("FAIL wr_rd_c2 got=%b/%b/%h exp=0000/0/20",
                     bus.rvalid, bus.ram_wren, bus.ram_address);
        end
        tick();
        checks++;
        if (bus.rvalid !== 4'b0010 || bus.rdata !== 8'h3C) begin
            failures++;
            $display("FAIL wr_rd_c3 got=%b/%h exp=0010/3c", bus.rvalid, bus.rdata);
        end
        tick();
        checks++;
        if (bus.rvalid !== 4'b0000) begin
            failures++;
            $display("FAIL wr_rd_c4 got=%b exp=0000", bus.rvalid);
        end
    endtask

    task automatic test_burst();
        logic [NREQ-1:0] exp_ack [10];
        exp_ack = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000,
                    4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000};
        do_reset();
        bus.req  = 4'b1010;
        bus.lock = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (bus.ack !== exp_ack[i]) begin
                failures++;
                $display("FAIL burst_cycle%0d got=%b exp=%b", i, bus.ack, exp_ack[i]);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        drive(2, 1'b0, 8'h10, 8'h00);
        #1;
        checks++;
        if (bus.ack !== 4'b0100) begin
            failures++;
            $display("FAIL mid_ack got=%b exp=0100", bus.ack);
        end
        tick();
        idle_inputs();
        reset = 1'b1;
        #1;
        checks++;
        if (bus.ram_wren !== 1'b0 || bus.ram_address !== 8'h00 || bus.ack !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset got=%b/%h/%b exp=0/00/0000",
                     bus.ram_wren, bus.ram_address, bus.ack);
        end
        tick();
        checks++;
        if (bus.rvalid !== 4'b0000) begin
            failures++;
            $display("FAIL mid_rvalid_c2 got=%b exp=0000", bus.rvalid);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (bus.rvalid !== 4'b0000) begin
            failures++;
            $display("FAIL mid_rvalid_c3 got=%b exp=0000", bus.rvalid);
        end
    endtask

`ifdef DPRAM_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        do_reset();
        bus.req  = 4'b0100;
        bus.lock = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.ack !== 4'b0100) begin
                failures++;
                $display("FAIL fp_burst%0d got=%b exp=0100", i, bus.ack);
            end
            tick();
        end
        bus.req[0] = 1'b1;
        #1;
        checks++;
        if (bus.ack !== 4'b0001) begin
            failures++;
            $display("FAIL fp_preempt got=%b exp=0001", bus.ack);
        end
        tick();
        #1;
        checks++;
        if (bus.ack !== 4'b0001) begin
            failures++;
            $display("FAIL fp_hold got=%b exp=0001", bus.ack);
        end
        tick();
        bus.req[0] = 1'b0;
        #1;
        checks++;
        if (bus.ack !== 4'b0100) begin
            failures++;
            $display("FAIL fp_resume got=%b exp=0100", bus.ack);
        end
        tick();
        idle_inputs();
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_read();
        test_burst();
        test_reset_mid_read();
`ifdef DPRAM_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
